// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the simpleRISC instruction-sequencing controller.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPDATE_PC,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU_OP,
    S_WRITE_REG,
    S_ADDR,
    S_LOAD_ADDR,
    S_MEM_RD,
    S_LDR_WB,
    S_STR_C,
    S_MEM_WR,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    I_NOP,
    I_MOV_IMM,
    I_MOV_REG,
    I_ADD,
    I_CMP,
    I_AND,
    I_MVN,
    I_LDR,
    I_STR,
    I_HALT
  } instr_e;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [3:0] {
    VSEL_NONE  = 4'b0000,
    VSEL_MDATA = 4'b0001,
    VSEL_IMM8  = 4'b0010,
    VSEL_PC    = 4'b0100,
    VSEL_C     = 4'b1000
  } vsel_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction, immediate sign extension and instruction classification.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [1:0]  op,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output instr_e      iclass
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // Unrecognised encodings fall through as I_NOP so DECODE returns to fetch.
  always_comb begin
    iclass = I_NOP;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      iclass = I_MOV_IMM;
        else if (op == OP_MOV_REG) iclass = I_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  iclass = I_ADD;
          OP_CMP:  iclass = I_CMP;
          OP_AND:  iclass = I_AND;
          OP_MVN:  iclass = I_MVN;
          default: iclass = I_NOP;
        endcase
      end
      OPC_LDR:  if (op == OP_MEM) iclass = I_LDR;
      OPC_STR:  if (op == OP_MEM) iclass = I_STR;
      OPC_HALT: iclass = I_HALT;
      default:  iclass = I_NOP;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// simpleRISC sequencer: fetch, decode and per-state datapath control, plus pc and data address.
module ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] read_data,
  input  logic [15:0] datapath_out,
  output logic [1:0]  mem_cmd,
  output logic [8:0]  mem_addr,
  output logic [8:0]  pc,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [3:0]  vsel,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [8:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [8:0]  data_addr_q, data_addr_d;

  logic [2:0]  rn, rd, rm;
  logic [1:0]  sh, op;
  instr_e      iclass;
  logic        unused_dp_hi;

  assign unused_dp_hi = ^datapath_out[15:9];
  assign pc           = pc_q;

  instr_decoder u_dec (
    .ir     (ir_q),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .op     (op),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .iclass (iclass)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RST;
      pc_q        <= '0;
      ir_q        <= '0;
      data_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      data_addr_q <= data_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    data_addr_d = data_addr_q;

    mem_cmd  = MEM_NONE;
    mem_addr = pc_q;
    vsel     = VSEL_NONE;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = '0;
    ALUop    = '0;
    halted   = 1'b0;

    case (state_q)
      S_RST: state_d = S_IF1;
      S_IF1: begin
        mem_cmd = MEM_READ;
        state_d = S_IF2;
      end
      // Memory has one cycle of latency, so the IR is captured at the end of IF2.
      S_IF2: begin
        mem_cmd = MEM_READ;
        ir_d    = read_data;
        state_d = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        pc_d    = pc_q + 9'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          I_MOV_IMM:                        state_d = S_WRITE_IMM;
          I_ADD, I_AND, I_CMP, I_LDR, I_STR: state_d = S_GET_A;
          I_MOV_REG, I_MVN:                 state_d = S_GET_B;
          I_HALT:                           state_d = S_HALT;
          default:                          state_d = S_IF1;
        endcase
      end
      S_WRITE_IMM: begin
        vsel     = VSEL_IMM8;
        writenum = rn;
        write    = 1'b1;
        state_d  = S_IF1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = (iclass == I_LDR || iclass == I_STR) ? S_ADDR : S_GET_B;
      end
      // STR reuses GET_B to fetch the store data register Rd.
      S_GET_B: begin
        readnum = (iclass == I_STR) ? rd : rm;
        loadb   = 1'b1;
        state_d = (iclass == I_STR) ? S_STR_C : S_ALU_OP;
      end
      S_ALU_OP: begin
        shift = sh;
        ALUop = op;
        asel  = (iclass == I_MOV_REG) || (iclass == I_MVN);
        if (iclass == I_CMP) begin
          loads   = 1'b1;
          state_d = S_IF1;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        vsel     = VSEL_C;
        writenum = rd;
        write    = 1'b1;
        state_d  = S_IF1;
      end
      S_ADDR: begin
        bsel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        data_addr_d = datapath_out[8:0];
        state_d     = (iclass == I_LDR) ? S_MEM_RD : S_GET_B;
      end
      S_MEM_RD: begin
        mem_addr = data_addr_q;
        mem_cmd  = MEM_READ;
        state_d  = S_LDR_WB;
      end
      S_LDR_WB: begin
        mem_addr = data_addr_q;
        mem_cmd  = MEM_READ;
        vsel     = VSEL_MDATA;
        writenum = rd;
        write    = 1'b1;
        state_d  = S_IF1;
      end
      S_STR_C: begin
        asel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_addr = data_addr_q;
        mem_cmd  = MEM_WRITE;
        state_d  = S_IF1;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: a per-cycle expected-output queue built from a program model.
module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] read_data;
  logic [15:0] datapath_out = 16'h0000;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [8:0]  pc;
  logic [15:0] sximm8, sximm5;
  logic [3:0]  vsel;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel, halted;
  logic [1:0]  shift, ALUop;

  ctrl_fsm dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .read_data    (read_data),
    .datapath_out (datapath_out),
    .mem_cmd      (mem_cmd),
    .mem_addr     (mem_addr),
    .pc           (pc),
    .sximm8       (sximm8),
    .sximm5       (sximm5),
    .vsel         (vsel),
    .readnum      (readnum),
    .writenum     (writenum),
    .write        (write),
    .loada        (loada),
    .loadb        (loadb),
    .loadc        (loadc),
    .loads        (loads),
    .asel         (asel),
    .bsel         (bsel),
    .shift        (shift),
    .ALUop        (ALUop),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Memory: data appears the cycle after READ; otherwise a HALT pattern so early capture shows up.
  logic [15:0] mem [0:511];
  always @(posedge clk) begin
    if (mem_cmd == 2'b01) read_data <= mem[mem_addr];
    else                  read_data <= 16'hFFFF;
  end

  typedef struct packed {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [8:0]  pcv;
    logic [3:0]  vsel;
    logic [2:0]  rn;
    logic [2:0]  wn;
    logic        wr, la, lb, lc, ls, asl, bsl;
    logic [1:0]  sh;
    logic [1:0]  alu;
    logic        hlt;
    logic [15:0] s8;
    logic [15:0] s5;
  } cv_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  cv_t         q[$];
  logic [8:0]  m_pc;
  logic [8:0]  m_daddr;
  logic [15:0] m_ir;

  function automatic cv_t blank(input logic [8:0] p, input logic [15:0] ir);
    cv_t v = '0;
    v.addr = p;
    v.pcv  = p;
    v.s8   = {{8{ir[7]}}, ir[7:0]};
    v.s5   = {{11{ir[4]}}, ir[4:0]};
    return v;
  endfunction

  function automatic cv_t sample();
    cv_t v;
    v.cmd = mem_cmd;  v.addr = mem_addr; v.pcv = pc;     v.vsel = vsel;
    v.rn  = readnum;  v.wn   = writenum; v.wr  = write;  v.la   = loada;
    v.lb  = loadb;    v.lc   = loadc;    v.ls  = loads;  v.asl  = asel;
    v.bsl = bsel;     v.sh   = shift;    v.alu = ALUop;  v.hlt  = halted;
    v.s8  = sximm8;   v.s5   = sximm5;
    return v;
  endfunction

  // Expected per-cycle outputs for one instruction fetched at m_pc.
  function automatic void push_instr(input logic [15:0] ir, input logic [15:0] dpo);
    cv_t        v;
    logic [8:0] p1;
    logic [2:0] opc = ir[15:13];
    logic [1:0] op  = ir[12:11];
    logic       two_src;
    p1 = m_pc + 9'd1;
    v = blank(m_pc, m_ir); v.cmd = 2'b01;
    q.push_back(v);
    q.push_back(v);
    q.push_back(blank(m_pc, ir));
    m_pc = p1;
    m_ir = ir;
    q.push_back(blank(p1, ir));
    if (opc == 3'b110 && op == 2'b10) begin
      v = blank(p1, ir); v.vsel = 4'b0010; v.wn = ir[10:8]; v.wr = 1'b1; q.push_back(v);
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      two_src = (opc == 3'b101) && (op != 2'b11);
      if (two_src) begin
        v = blank(p1, ir); v.rn = ir[10:8]; v.la = 1'b1; q.push_back(v);
      end
      v = blank(p1, ir); v.rn = ir[2:0]; v.lb = 1'b1; q.push_back(v);
      v = blank(p1, ir); v.sh = ir[4:3]; v.alu = op; v.asl = !two_src;
      if (opc == 3'b101 && op == 2'b01) v.ls = 1'b1;
      else                              v.lc = 1'b1;
      q.push_back(v);
      if (!(opc == 3'b101 && op == 2'b01)) begin
        v = blank(p1, ir); v.vsel = 4'b1000; v.wn = ir[7:5]; v.wr = 1'b1; q.push_back(v);
      end
    end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
      v = blank(p1, ir); v.rn = ir[10:8]; v.la = 1'b1; q.push_back(v);
      v = blank(p1, ir); v.bsl = 1'b1; v.lc = 1'b1; q.push_back(v);
      q.push_back(blank(p1, ir));
      m_daddr = dpo[8:0];
      if (opc == 3'b011) begin
        v = blank(p1, ir); v.cmd = 2'b01; v.addr = m_daddr; q.push_back(v);
        v.vsel = 4'b0001; v.wn = ir[7:5]; v.wr = 1'b1; q.push_back(v);
      end else begin
        v = blank(p1, ir); v.rn = ir[7:5]; v.lb = 1'b1; q.push_back(v);
        v = blank(p1, ir); v.asl = 1'b1; v.lc = 1'b1; q.push_back(v);
        v = blank(p1, ir); v.cmd = 2'b10; v.addr = m_daddr; q.push_back(v);
      end
    end
  endfunction

  function automatic void push_halt(input int unsigned n);
    cv_t v = blank(m_pc, m_ir);
    v.hlt = 1'b1;
    for (int unsigned i = 0; i < n; i++) q.push_back(v);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    q.delete();
    m_pc = '0; m_ir = '0; m_daddr = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    cv_t e, o;
    @(negedge clk);
    e = blank(9'd0, 16'h0000); o = sample();
    checks++;
    if (o !== e) begin failures++; $display("FAIL reset_state got=%h exp=%h", o, e); end
    reset_n = 1'b1;
    @(negedge clk);
    e.cmd = 2'b01; o = sample();
    checks++;
    if (o !== e) begin failures++; $display("FAIL reset_to_if1 got=%h exp=%h", o, e); end
  endtask

  task automatic test_mov_halt();
    cv_t e, o;
    int unsigned n = 0;
    clear_mem();
    mem[0] = 16'hD005; mem[1] = 16'hE000;
    do_reset();
    push_instr(16'hD005, 16'h0000);
    push_instr(16'hE000, 16'h0000);
    push_halt(6);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL mov_halt[%0d] got=%h exp=%h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_alu_seq();
    cv_t e, o;
    int unsigned n = 0;
    logic [15:0] prog [0:8];
    prog = '{16'hD1FE, 16'hA140, 16'hA900, 16'hC049, 16'hB862,
             16'hB180, 16'h0000, 16'h7800, 16'hE000};
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = prog[i];
    do_reset();
    for (int i = 0; i < 9; i++) push_instr(prog[i], 16'h0000);
    push_halt(3);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL alu_seq[%0d] got=%h exp=%h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_ldr();
    cv_t e, o;
    int unsigned n = 0;
    clear_mem();
    mem[0] = 16'h6061; mem[1] = 16'hE000; mem[6] = 16'h1234;
    datapath_out = 16'h0006;
    do_reset();
    push_instr(16'h6061, 16'h0006);
    push_instr(16'hE000, 16'h0006);
    push_halt(2);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL ldr[%0d] got=%h exp=%h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_str();
    cv_t e, o;
    int unsigned n = 0;
    clear_mem();
    mem[0] = 16'h8062; mem[1] = 16'hE000;
    datapath_out = 16'h0006;
    do_reset();
    push_instr(16'h8062, 16'h0006);
    push_instr(16'hE000, 16'h0006);
    push_halt(2);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL str[%0d] got=%h exp=%h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    cv_t e, o;
    int unsigned n = 0;
    clear_mem();
    mem[0] = 16'h6061; mem[1] = 16'h8062; mem[2] = 16'hA140; mem[3] = 16'hE000;
    datapath_out = 16'hFFF5;
    do_reset();
    push_instr(16'h6061, 16'hFFF5);
    push_instr(16'h8062, 16'hFFF5);
    push_instr(16'hA140, 16'hFFF5);
    push_instr(16'hE000, 16'hFFF5);
    push_halt(2);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL back_to_back[%0d] got=%h exp=%h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_pc_wrap();
    cv_t e, o;
    int unsigned n = 0;
    clear_mem();
    datapath_out = 16'h0000;
    do_reset();
    for (int i = 0; i < 512; i++) push_instr(16'h0000, 16'h0000);
    e = blank(m_pc, m_ir); e.cmd = 2'b01;
    q.push_back(e);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL pc_wrap[%0d] got=%h exp=%h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    cv_t e, o;
    clear_mem();
    mem[0] = 16'hA140;
    do_reset();
    push_instr(16'hA140, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e = q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL mid_pre[%0d] got=%h exp=%h", i, o, e); end
    end
    reset_n = 1'b0;
    #1;
    q.delete();
    m_pc = '0; m_ir = '0; m_daddr = '0;
    e = blank(9'd0, 16'h0000); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL mid_async got=%h exp=%h", o, e); end
    @(negedge clk);
    o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL mid_hold got=%h exp=%h", o, e); end
    reset_n = 1'b1;
    @(negedge clk);
    e.cmd = 2'b01; o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL mid_restart got=%h exp=%h", o, e); end
  endtask

  initial begin
    clear_mem();
    m_pc = '0; m_ir = '0; m_daddr = '0;
    test_reset();
    test_mov_halt();
    test_alu_seq();
    test_ldr();
    test_str();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
